// File: rtl/multi_cycle_controller.sv
// Multi-cycle RISC-V style control FSM with optional memory-wait watchdog and retire counter.
// Defining MULTI_CYCLE_CONTROLLER_PERFCNT_EN enables the retired-instruction counter.
module multi_cycle_controller #(
  parameter int CNT_W      = 32,
  parameter int WAIT_LIMIT = 0
) (
  input  logic             i_clk,
  input  logic             i_srst,
  input  logic [6:0]       i_opcode,
  input  logic [2:0]       i_funct3,
  input  logic             i_funct7bit5,
  input  logic             i_zeroFlag,
  input  logic             i_memReady,
  output logic             o_memReq,
  output logic             o_addressSrc,
  output logic             o_memWriteEn,
  output logic             o_instructionRegWrite,
  output logic             o_pcWriteEn,
  output logic             o_regWriteEn,
  output logic [1:0]       o_resultSel,
  output logic [1:0]       o_aluInputASel,
  output logic [1:0]       o_aluInputBSel,
  output logic [3:0]       o_aluOp,
  output logic [3:0]       o_state,
  output logic             o_illegal,
  output logic [CNT_W-1:0] o_retiredCount
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BEQ      = 4'd9,
    JAL      = 4'd10,
    TRAP     = 4'd15
  } stateT;

  localparam logic [1:0] A_PC = 2'd0, A_OLDPC = 2'd1, A_RD1 = 2'd2;
  localparam logic [1:0] B_RD2 = 2'd0, B_IMM = 2'd1, B_FOUR = 2'd2;
  localparam logic [1:0] RES_ALUOUT = 2'd0, RES_DATA = 2'd1, RES_ALURESULT = 2'd2;
  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR = 4'd3, OP_SLT = 4'd4;

  stateT      stateReg, stateNext;
  logic       memReq, addressSrc, memWriteEn, instructionRegWrite;
  logic       pcWriteEn, regWriteEn, illegal;
  logic [1:0] resultSel, aluInputASel, aluInputBSel;
  logic [3:0] aluOp, funct3Op;
  logic       funct3Ok;
  logic       waitAtLimit;

  always_ff @(posedge i_clk) begin
    if (i_srst) stateReg <= FETCH;
    else        stateReg <= stateNext;
  end

  always_comb begin
    funct3Ok = 1'b1;
    funct3Op = OP_ADD;
    case (i_funct3)
      3'b000:  funct3Op = OP_ADD;
      3'b010:  funct3Op = OP_SLT;
      3'b110:  funct3Op = OP_OR;
      3'b111:  funct3Op = OP_AND;
      default: funct3Ok = 1'b0;
    endcase
  end

  always_comb begin
    stateNext           = stateReg;
    memReq              = 1'b0;
    addressSrc          = 1'b0;
    memWriteEn          = 1'b0;
    instructionRegWrite = 1'b0;
    pcWriteEn           = 1'b0;
    regWriteEn          = 1'b0;
    illegal             = 1'b0;
    resultSel           = RES_ALUOUT;
    aluInputASel        = A_PC;
    aluInputBSel        = B_RD2;
    aluOp               = OP_ADD;
    case (stateReg)
      FETCH: begin
        memReq = 1'b1;
        if (i_memReady) begin
          instructionRegWrite = 1'b1;
          pcWriteEn           = 1'b1;
          aluInputBSel        = B_FOUR;
          resultSel           = RES_ALURESULT;
          stateNext           = DECODE;
        end
      end
      DECODE: begin
        aluInputASel = A_OLDPC;
        aluInputBSel = B_IMM;
        case (i_opcode)
          7'b0000011, 7'b0100011: stateNext = MEMADR;
          7'b0110011:             stateNext = EXECR;
          7'b0010011:             stateNext = EXECI;
          7'b1100011:             stateNext = BEQ;
          7'b1101111:             stateNext = JAL;
          default:                stateNext = TRAP;
        endcase
      end
      MEMADR: begin
        aluInputASel = A_RD1;
        aluInputBSel = B_IMM;
        // Opcode bit 5 separates store (0100011) from load (0000011).
        stateNext    = i_opcode[5] ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        memReq     = 1'b1;
        addressSrc = 1'b1;
        if (i_memReady) stateNext = MEMWB;
      end
      MEMWB: begin
        regWriteEn = 1'b1;
        resultSel  = RES_DATA;
        stateNext  = FETCH;
      end
      MEMWRITE: begin
        memReq     = 1'b1;
        memWriteEn = 1'b1;
        addressSrc = 1'b1;
        if (i_memReady) stateNext = FETCH;
      end
      EXECR: begin
        aluInputASel = A_RD1;
        aluInputBSel = B_RD2;
        aluOp        = (i_funct3 == 3'b000 && i_funct7bit5) ? OP_SUB : funct3Op;
        stateNext    = funct3Ok ? ALUWB : TRAP;
      end
      EXECI: begin
        aluInputASel = A_RD1;
        aluInputBSel = B_IMM;
        aluOp        = funct3Op;
        stateNext    = funct3Ok ? ALUWB : TRAP;
      end
      ALUWB: begin
        regWriteEn = 1'b1;
        resultSel  = RES_ALUOUT;
        stateNext  = FETCH;
      end
      BEQ: begin
        aluInputASel = A_RD1;
        aluInputBSel = B_RD2;
        aluOp        = OP_SUB;
        resultSel    = RES_ALUOUT;
        if (i_funct3 == 3'b000) begin
          pcWriteEn = i_zeroFlag;
          stateNext = FETCH;
        end else begin
          stateNext = TRAP;
        end
      end
      JAL: begin
        aluInputASel = A_OLDPC;
        aluInputBSel = B_FOUR;
        resultSel    = RES_ALUOUT;
        pcWriteEn    = 1'b1;
        stateNext    = ALUWB;
      end
      TRAP:    illegal   = 1'b1;
      default: stateNext = TRAP;
    endcase
    if (memReq && !i_memReady && waitAtLimit) stateNext = TRAP;
  end

  generate
    if (WAIT_LIMIT > 0) begin : gWait
      localparam int WW = $clog2(WAIT_LIMIT + 1);
      logic [WW-1:0] waitCntReg;
      // Counts consecutive stalled request cycles within one state.
      always_ff @(posedge i_clk) begin
        if (i_srst)
          waitCntReg <= '0;
        else if (memReq && !i_memReady && stateNext == stateReg)
          waitCntReg <= waitCntReg + WW'(1);
        else
          waitCntReg <= '0;
      end
      assign waitAtLimit = (waitCntReg == WW'(WAIT_LIMIT - 1));
    end else begin : gNoWait
      assign waitAtLimit = 1'b0;
    end
  endgenerate

`ifdef MULTI_CYCLE_CONTROLLER_PERFCNT_EN
  logic [CNT_W-1:0] retiredReg;
  logic             retireEvent;
  assign retireEvent = (stateNext == FETCH) &&
                       (stateReg inside {MEMWB, MEMWRITE, ALUWB, BEQ});
  always_ff @(posedge i_clk) begin
    if (i_srst)           retiredReg <= '0;
    else if (retireEvent) retiredReg <= retiredReg + CNT_W'(1);
  end
  assign o_retiredCount = i_srst ? '0 : retiredReg;
`else
  assign o_retiredCount = '0;
`endif

  // Reset forces every output low even before the state register has been cleared.
  assign o_memReq              = memReq & ~i_srst;
  assign o_addressSrc          = addressSrc & ~i_srst;
  assign o_memWriteEn          = memWriteEn & ~i_srst;
  assign o_instructionRegWrite = instructionRegWrite & ~i_srst;
  assign o_pcWriteEn           = pcWriteEn & ~i_srst;
  assign o_regWriteEn          = regWriteEn & ~i_srst;
  assign o_illegal             = illegal & ~i_srst;
  assign o_resultSel           = i_srst ? 2'd0 : resultSel;
  assign o_aluInputASel        = i_srst ? 2'd0 : aluInputASel;
  assign o_aluInputBSel        = i_srst ? 2'd0 : aluInputBSel;
  assign o_aluOp               = i_srst ? 4'd0 : aluOp;
  assign o_state               = i_srst ? 4'd0 : stateReg;

endmodule

// File: tb/tb_multi_cycle_controller.sv
// Randomized and directed bench for multi_cycle_controller against a per-instruction state-sequence model.
module tb_multi_cycle_controller;

  localparam int CW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       srst = 1'b1, srst2 = 1'b1;
  logic [6:0] opcode = '0;
  logic [2:0] funct3 = '0;
  logic       f7 = 1'b0, zf = 1'b0, rdy = 1'b0, rdy2 = 1'b0;

  logic memReq, addrSrc, memWe, irWr, pcWe, regWe, illegal;
  logic [1:0] resSel, aSel, bSel;
  logic [3:0] aluOp, state;
  logic [CW-1:0] retiredCnt;

  logic memReq2, addrSrc2, memWe2, irWr2, pcWe2, regWe2, illegal2;
  logic [1:0] resSel2, aSel2, bSel2;
  logic [3:0] aluOp2, state2;
  logic [31:0] retiredCnt2;

  multi_cycle_controller #(.CNT_W(CW), .WAIT_LIMIT(0)) dut (
    .i_clk(clk), .i_srst(srst), .i_opcode(opcode), .i_funct3(funct3),
    .i_funct7bit5(f7), .i_zeroFlag(zf), .i_memReady(rdy),
    .o_memReq(memReq), .o_addressSrc(addrSrc), .o_memWriteEn(memWe),
    .o_instructionRegWrite(irWr), .o_pcWriteEn(pcWe), .o_regWriteEn(regWe),
    .o_resultSel(resSel), .o_aluInputASel(aSel), .o_aluInputBSel(bSel),
    .o_aluOp(aluOp), .o_state(state), .o_illegal(illegal), .o_retiredCount(retiredCnt)
  );

  multi_cycle_controller #(.CNT_W(32), .WAIT_LIMIT(4)) dut2 (
    .i_clk(clk), .i_srst(srst2), .i_opcode(opcode), .i_funct3(funct3),
    .i_funct7bit5(f7), .i_zeroFlag(zf), .i_memReady(rdy2),
    .o_memReq(memReq2), .o_addressSrc(addrSrc2), .o_memWriteEn(memWe2),
    .o_instructionRegWrite(irWr2), .o_pcWriteEn(pcWe2), .o_regWriteEn(regWe2),
    .o_resultSel(resSel2), .o_aluInputASel(aSel2), .o_aluInputBSel(bSel2),
    .o_aluOp(aluOp2), .o_state(state2), .o_illegal(illegal2), .o_retiredCount(retiredCnt2)
  );

  typedef struct {
    int st;
    bit rdy;
    bit retire;
    bit maskPc;
  } stepT;

  int checks = 0;
  int passes = 0;
  int retired = 0;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [3:0] aluCode(logic [2:0] f, bit sub);
    case (f)
      3'd0:    return sub ? 4'd1 : 4'd0;
      3'd2:    return 4'd4;
      3'd6:    return 4'd3;
      3'd7:    return 4'd2;
      default: return 4'd0;
    endcase
  endfunction

  // Control word expected in each state, taken straight from the state table.
  function automatic logic [20:0] expCtrl(int st, bit r, bit z, logic [2:0] f, bit s7);
    bit mr = 0, as = 0, mw = 0, ir = 0, pw = 0, rw = 0, il = 0;
    logic [1:0] rs = 0, a = 0, b = 0;
    logic [3:0] op = 0;
    logic [3:0] s4;
    s4 = st[3:0];
    case (st)
      0:  begin mr = 1; if (r) begin ir = 1; pw = 1; b = 2; rs = 2; end end
      1:  begin a = 1; b = 1; end
      2:  begin a = 2; b = 1; end
      3:  begin mr = 1; as = 1; end
      4:  begin rw = 1; rs = 1; end
      5:  begin mr = 1; mw = 1; as = 1; end
      6:  begin a = 2; op = aluCode(f, s7); end
      7:  begin a = 2; b = 1; op = aluCode(f, 1'b0); end
      8:  rw = 1;
      9:  begin a = 2; op = 1; pw = z; end
      10: begin a = 1; b = 2; pw = 1; end
      15: il = 1;
      default: ;
    endcase
    return {mr, as, mw, ir, pw, rw, rs, a, b, op, s4, il};
  endfunction

  function automatic logic [31:0] expRetired();
`ifdef MULTI_CYCLE_CONTROLLER_PERFCNT_EN
    return 32'(retired % (1 << CW));
`else
    return 32'd0;
`endif
  endfunction

  function automatic logic [20:0] actCtrl();
    return {memReq, addrSrc, memWe, irWr, pcWe, regWe, resSel, aSel, bSel, aluOp, state, illegal};
  endfunction

  task automatic stepCheck(int st, bit maskPc);
    logic [20:0] e, a;
    @(negedge clk);
    e = expCtrl(st, rdy, zf, funct3, f7);
    a = actCtrl();
    if (maskPc) begin e[16] = 1'b0; a[16] = 1'b0; end
    check($sformatf("ctrl st%0d", st), 32'(a), 32'(e));
    check("retired", 32'(retiredCnt), expRetired());
    @(posedge clk); #1;
  endtask

  task automatic doReset();
    srst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      rdy = 1'($urandom);
      @(negedge clk);
      check("reset ctrl", 32'(actCtrl()), 32'd0);
      check("reset retired", 32'(retiredCnt), 32'd0);
      @(posedge clk); #1;
    end
    retired = 0;
    srst = 1'b0;
  endtask

  task automatic runInstr(logic [31:0] ins, int fw, int mw, bit z, int abortAt, int trapCycles);
    stepT q[$];
    bit legal;
    opcode = ins[6:0];
    funct3 = ins[14:12];
    f7 = ins[30];
    zf = z;
    legal = (funct3 inside {3'd0, 3'd2, 3'd6, 3'd7});
    for (int i = 0; i < fw; i++) q.push_back('{0, 1'b0, 1'b0, 1'b0});
    q.push_back('{0, 1'b1, 1'b0, 1'b0});
    q.push_back('{1, 1'($urandom), 1'b0, 1'b0});
    case (opcode)
      7'h03: begin
        q.push_back('{2, 1'($urandom), 1'b0, 1'b0});
        for (int i = 0; i < mw; i++) q.push_back('{3, 1'b0, 1'b0, 1'b0});
        q.push_back('{3, 1'b1, 1'b0, 1'b0});
        q.push_back('{4, 1'($urandom), 1'b1, 1'b0});
      end
      7'h23: begin
        q.push_back('{2, 1'($urandom), 1'b0, 1'b0});
        for (int i = 0; i < mw; i++) q.push_back('{5, 1'b0, 1'b0, 1'b0});
        q.push_back('{5, 1'b1, 1'b1, 1'b0});
      end
      7'h33, 7'h13: begin
        q.push_back('{(opcode == 7'h33) ? 6 : 7, 1'($urandom), 1'b0, 1'b0});
        if (legal) q.push_back('{8, 1'($urandom), 1'b1, 1'b0});
        else       q.push_back('{15, 1'($urandom), 1'b0, 1'b0});
      end
      7'h63: begin
        q.push_back('{9, 1'($urandom), funct3 == 3'd0, funct3 != 3'd0});
        if (funct3 != 3'd0) q.push_back('{15, 1'($urandom), 1'b0, 1'b0});
      end
      7'h6F: begin
        q.push_back('{10, 1'($urandom), 1'b0, 1'b0});
        q.push_back('{8, 1'($urandom), 1'b1, 1'b0});
      end
      default: q.push_back('{15, 1'($urandom), 1'b0, 1'b0});
    endcase
    if (q[$].st == 15)
      for (int i = 1; i < trapCycles; i++) q.push_back('{15, 1'($urandom), 1'b0, 1'b0});
    foreach (q[i]) begin
      if (i == abortAt) begin
        doReset();
        return;
      end
      rdy = q[i].rdy;
      stepCheck(q[i].st, q[i].maskPc);
      if (q[i].retire) retired++;
    end
    if (q[$].st == 15) doReset();
  endtask

  initial begin
    logic [31:0] w;
    logic [6:0]  ops [7];
    ops = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h6F, 7'h00};
    @(posedge clk); #1;
    doReset();

    runInstr(32'h002081B3, 0, 0, 1'b0, -1, 3);  // add
    runInstr(32'h40208133, 1, 0, 1'b0, -1, 3);  // sub
    runInstr(32'h0040A183, 0, 3, 1'b0, -1, 3);  // lw, 3 wait cycles
    runInstr(32'h0020A223, 2, 2, 1'b0, -1, 3);  // sw
    runInstr(32'h00108093, 0, 0, 1'b0, -1, 3);  // addi
    runInstr(32'h00000063, 0, 0, 1'b1, -1, 3);  // beq taken
    runInstr(32'h00000063, 0, 0, 1'b0, -1, 3);  // beq not taken
    runInstr(32'h0000006F, 0, 0, 1'b0, -1, 3);  // jal
    runInstr(32'h0000007F, 0, 0, 1'b0, -1, 10); // illegal opcode
    runInstr(32'h0040A183, 0, 5, 1'b0, 4, 3);   // reset during MEMREAD wait

    for (int n = 0; n < 17; n++) runInstr(32'h002081B3, 0, 0, 1'b0, -1, 3);
    @(negedge clk);
`ifdef MULTI_CYCLE_CONTROLLER_PERFCNT_EN
    check("wrap after 17", 32'(retiredCnt), 32'd1);
`else
    check("wrap after 17", 32'(retiredCnt), 32'd0);
`endif
    @(posedge clk); #1;

    for (int n = 0; n < 60; n++) begin
      w = '0;
      w[6:0] = ops[$urandom_range(6)];
      if (w[6:0] == 7'h00) begin
        w[6:0] = 7'($urandom);
        if (w[6:0] inside {7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h6F}) w[6:0] = 7'h7F;
      end
      w[14:12] = ($urandom_range(3) == 0) ? 3'($urandom) : 3'd0;
      if (w[6:0] inside {7'h03, 7'h23}) w[14:12] = 3'd2;
      else if (w[14:12] == 3'd0 && $urandom_range(1) == 1) w[14:12] = ($urandom_range(1) == 1) ? 3'd6 : 3'd7;
      w[30] = 1'($urandom);
      runInstr(w, $urandom_range(2), $urandom_range(3), 1'($urandom), -1, 3);
    end

    // Watchdog instance: memory never answers in FETCH.
    rdy2 = 1'b0;
    srst2 = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check($sformatf("wd fetch c%0d", c), {memReq2, 27'd0, state2}, {1'b1, 31'd0});
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("wd trap state", 32'(state2), 32'd15);
    check("wd trap illegal", 32'(illegal2), 32'd1);
    @(posedge clk); #1;
    srst2 = 1'b1;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/multi_cycle_controller.md
MULTI_CYCLE_CONTROLLER -- requirements
Module: multi_cycle_controller

Interface
REQ-001 SHALL have parameter CNT_W, default 32: width of retired-instruction counter.
REQ-002 SHALL have parameter WAIT_LIMIT, default 0: maximum i_memReady wait cycles per access; 0 = unlimited.
REQ-003 SHALL have ports, one per line:
  i_clk  input  1  sole clock, rising edge.
  i_srst  input  1  synchronous, active-high reset.
  i_opcode  input  7  instruction_q[6:0].
  i_funct3  input  3  instruction_q[14:12].
  i_funct7bit5  input  1  instruction_q[30].
  i_zeroFlag  input  1  ALU zero flag.
  i_memReady  input  1  memory access completes this cycle.
  o_memReq  output  1  memory access request.
  o_addressSrc  output  1  0 = PC, 1 = registered ALU output.
  o_memWriteEn  output  1  memory write.
  o_instructionRegWrite  output  1  load instruction register.
  o_pcWriteEn  output  1  load PC from result bus.
  o_regWriteEn  output  1  register-file write.
  o_resultSel  output  2  0 = ALUOUT (registered), 1 = DATA, 2 = ALURESULT (combinational).
  o_aluInputASel  output  2  0 = PC, 1 = OLDPC, 2 = RD1.
  o_aluInputBSel  output  2  0 = RD2, 1 = IMM, 2 = FOUR.
  o_aluOp  output  4  0 = ADD, 1 = SUB, 2 = AND, 3 = OR, 4 = SLT.
  o_state  output  4  current state encoding.
  o_illegal  output  1  sticky trap flag.
  o_retiredCount  output  CNT_W  retired instructions.

Function
REQ-004 SHALL encode states FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BEQ=9, JAL=10, TRAP=15.
REQ-005 SHALL drive every control output combinationally from state (plus i_memReady, i_zeroFlag); unlisted outputs are 0 in each state.
REQ-006 FETCH: o_memReq=1, o_addressSrc=0; while i_memReady=0 hold FETCH; on i_memReady=1, o_instructionRegWrite=1, o_pcWriteEn=1, A=PC, B=FOUR, ADD, resultSel=ALURESULT, then go to DECODE.
REQ-007 DECODE: A=OLDPC, B=IMM, ADD; next state by opcode: 0000011/0100011 -> MEMADR, 0110011 -> EXECR, 0010011 -> EXECI, 1100011 -> BEQ, 1101111 -> JAL, any other -> TRAP.
REQ-008 MEMADR: A=RD1, B=IMM, ADD; lw -> MEMREAD, sw -> MEMWRITE.
REQ-009 MEMREAD: o_memReq=1, o_addressSrc=1; hold until i_memReady=1, then go to MEMWB. MEMWB: o_regWriteEn=1, resultSel=DATA, then go to FETCH.
REQ-010 MEMWRITE: o_memReq=1, o_memWriteEn=1, o_addressSrc=1, all held stable until i_memReady=1, then go to FETCH.
REQ-011 EXECR: A=RD1, B=RD2; EXECI: A=RD1, B=IMM; both then go to ALUWB. ALUWB: o_regWriteEn=1, resultSel=ALUOUT, then go to FETCH.
REQ-012 ALU decode: funct3 000 -> ADD, except SUB when EXECR and i_funct7bit5=1; 010 -> SLT; 110 -> OR; 111 -> AND; any other funct3 in EXECR/EXECI -> TRAP instead of ALUWB.
REQ-013 BEQ: A=RD1, B=RD2, SUB, resultSel=ALUOUT, o_pcWriteEn=i_zeroFlag; funct3 other than 000 -> TRAP; otherwise go to FETCH.
REQ-014 JAL: A=OLDPC, B=FOUR, ADD, resultSel=ALUOUT, o_pcWriteEn=1, then go to ALUWB.
REQ-015 TRAP: o_illegal=1, all other controls 0; TRAP is absorbing until i_srst.
REQ-016 WAIT_LIMIT>0: an internal counter counts consecutive cycles with o_memReq=1 and i_memReady=0. On reaching WAIT_LIMIT, go to TRAP. The counter clears on every i_memReady=1 or state change.
REQ-017 A retire event SHALL be the transition into FETCH from MEMWB, MEMWRITE, ALUWB, or BEQ; JAL retires via ALUWB.

Reset
REQ-018 While i_srst=1, all outputs SHALL be 0, state SHALL be FETCH, and the wait counter, o_illegal, and o_retiredCount SHALL be 0.
REQ-019 Reset asserted mid-instruction, including during a memory wait, SHALL abandon the instruction with no retire event; the first cycle after release SHALL be FETCH with o_memReq=1.

Configuration
REQ-020 Macro MULTI_CYCLE_CONTROLLER_PERFCNT_EN defined: o_retiredCount increments by 1 on each retire event and wraps from 2^CNT_W-1 to 0.
REQ-021 Macro undefined: o_retiredCount SHALL be constant 0, with no counter flops.

Verification
REQ-022 add (0x002081B3), i_memReady always 1 -> states 0,1,6,8,0; o_regWriteEn high exactly 1 cycle; o_aluOp=0.
REQ-023 lw (0x0040A183), i_memReady low 3 cycles in MEMREAD -> MEMREAD held 4 cycles with o_addressSrc=1; then MEMWB with o_resultSel=1.
REQ-024 beq, i_zeroFlag=1 then 0 on a rerun -> o_pcWriteEn=1 in BEQ in the first run, 0 in the second; o_aluOp=1 in both.
REQ-025 opcode 0x7F -> TRAP after DECODE; o_illegal=1 held for 10 cycles; i_srst pulse -> FETCH, o_illegal=0.
REQ-026 WAIT_LIMIT=4, i_memReady stuck 0 in FETCH -> TRAP after 4 cycles.
REQ-027 PERFCNT_EN, CNT_W=4, 17 retirements -> o_retiredCount=1; macro undefined -> o_retiredCount=0 throughout.
